// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared AXI4-Lite definitions for the master bridge: response codes, the
// bridge FSM state encoding, channel field widths and the error decode helper.
// -----------------------------------------------------------------------------
package axil_pkg;

    localparam int unsigned RESP_WIDTH = 2;
    localparam int unsigned PROT_WIDTH = 3;

    // Unprivileged, secure, data access on every request.
    localparam logic [PROT_WIDTH-1:0] AXI_PROT_DEFAULT = PROT_WIDTH'(0);

    typedef enum logic [RESP_WIDTH-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    // SLVERR and DECERR are failures; OKAY and EXOKAY both count as success.
    function automatic logic resp_is_err(input logic [RESP_WIDTH-1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_master_bridge_if.sv
// -----------------------------------------------------------------------------
// axil_master_bridge_if
// Bundles the simple core memory port and the five AXI4-Lite master channels.
//   master modport : bridge view (accepts core requests, drives AXI requests)
//   slave  modport : environment view (core + AXI slave)
// Core side : mem_req/mem_we/mem_be/mem_addr/mem_wdata in,
//             mem_gnt/mem_rvalid/mem_rdata/mem_err out
// AXI side  : aw*, w*, ar* request channels out; b*, r* response channels in
// -----------------------------------------------------------------------------
interface axil_master_bridge_if
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Core memory port
    logic                  mem_req;
    logic                  mem_gnt;
    logic                  mem_we;
    logic [STRB_WIDTH-1:0] mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_err;

    // Write address channel
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [PROT_WIDTH-1:0] m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    // Write data channel
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    // Write response channel
    logic [RESP_WIDTH-1:0] m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    // Read address channel
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [PROT_WIDTH-1:0] m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    // Read data channel
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [RESP_WIDTH-1:0] m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/axil_master_bridge.sv
// -----------------------------------------------------------------------------
// axil_master_bridge
// Converts single core memory requests into AXI4-Lite transactions with
// exactly one transaction outstanding. Completion is reported by a one-cycle
// mem_rvalid pulse carrying read data (zero for writes) and an error flag.
// Ports:
//   m_axi_aclk    in  sole clock, rising edge
//   m_axi_areset  in  synchronous active-high reset
//   bus           master modport of axil_master_bridge_if (core port + AXI)
// -----------------------------------------------------------------------------
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_areset,
    axil_master_bridge_if.master bus
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] be_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic                  rready_q;
    logic                  mem_rvalid_q;
    logic                  mem_err_q;
    logic [DATA_WIDTH-1:0] mem_rdata_q;

    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    logic b_fire;
    logic r_fire;

    // Channel handshakes completing on the coming edge.
    assign aw_fire = awvalid_q && bus.m_axi_awready;
    assign w_fire  = wvalid_q  && bus.m_axi_wready;
    assign ar_fire = arvalid_q && bus.m_axi_arready;
    assign b_fire  = bready_q  && bus.m_axi_bvalid;
    assign r_fire  = rready_q  && bus.m_axi_rvalid;

    // Grant is the only combinational output: accepting in IDLE lets a new
    // request overlap the completion pulse of the previous one.
    assign bus.mem_gnt    = (state == IDLE) && bus.mem_req;
    assign bus.mem_rvalid = mem_rvalid_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_err    = mem_err_q;

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = AXI_PROT_DEFAULT;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = be_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = AXI_PROT_DEFAULT;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

    // Transaction FSM with registered channel controls and completion outputs.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            mem_rvalid_q <= 1'b0;
            mem_err_q    <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            mem_rvalid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.mem_req) begin
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        be_q    <= bus.mem_be;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (bus.mem_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end

                // AW and W retire independently, in either order or together.
                WR_REQ: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (b_fire) begin
                        bready_q     <= 1'b0;
                        mem_rvalid_q <= 1'b1;
                        mem_err_q    <= resp_is_err(bus.m_axi_bresp);
                        mem_rdata_q  <= '0;
                        state        <= IDLE;
                    end
                end

                RD_REQ: begin
                    if (ar_fire) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (r_fire) begin
                        rready_q     <= 1'b0;
                        mem_rvalid_q <= 1'b1;
                        mem_err_q    <= resp_is_err(bus.m_axi_rresp);
                        mem_rdata_q  <= bus.m_axi_rdata;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_axil_master_bridge
// Drives core requests into the bridge and answers on AXI with a gpio-like
// slave model (word 0 reads gpio_in, word 1 low half drives gpio_out, other
// words are plain storage) whose ready/response timing is configurable.
// -----------------------------------------------------------------------------
module tb_axil_master_bridge;
    import axil_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    axil_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (areset),
        .bus          (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic rst_seen = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_seen <= areset;

    // Slave configuration
    int          aw_delay, w_delay, ar_delay, b_delay, r_delay;
    bit          r_hold;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [15:0] gpio_in;
    logic [31:0] smem [16];
    logic [15:0] gpio_out;
    assign gpio_out = smem[1][15:0];

    // Observations
    wr_t wlog[$];
    int  aw_hs_cyc, w_hs_cyc, b_hs_count, rv_count, proto_err;
    int  gnt_count, last_gnt_cyc;

    // Reference memory image for words 4..15
    logic [31:0] shadow [16];

    // ------------------------------------------------------------------ slave
    initial begin : slave
        bit          have_aw, have_w, rd_pend;
        logic [31:0] aw_addr_s, w_data_s, rd_addr_s;
        logic [3:0]  w_strb_s;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        int          idx;

        for (int i = 0; i < 16; i++) smem[i] = '0;
        {have_aw, have_w, rd_pend} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
        {aw_addr_s, w_data_s, rd_addr_s, w_strb_s} = '0;
        {p_awaddr, p_wdata, p_araddr, p_wstrb} = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rdata   = '0;

        forever begin
            @(negedge clk);
            if (rst_seen) begin
                {have_aw, have_w, rd_pend} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
                bus.m_axi_awready = 1'b0;
                bus.m_axi_wready  = 1'b0;
                bus.m_axi_arready = 1'b0;
                bus.m_axi_bvalid  = 1'b0;
                bus.m_axi_rvalid  = 1'b0;
                continue;
            end

            // Protocol watch: hold until ready with stable payload, drop after.
            if (p_awv && p_awr && bus.m_axi_awvalid) proto_err++;
            if (p_awv && !p_awr && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== p_awaddr)) proto_err++;
            if (p_wv && p_wr && bus.m_axi_wvalid) proto_err++;
            if (p_wv && !p_wr && (!bus.m_axi_wvalid || bus.m_axi_wdata !== p_wdata ||
                                  bus.m_axi_wstrb !== p_wstrb)) proto_err++;
            if (p_arv && p_arr && bus.m_axi_arvalid) proto_err++;
            if (p_arv && !p_arr && (!bus.m_axi_arvalid || bus.m_axi_araddr !== p_araddr)) proto_err++;
            if (bus.m_axi_awvalid && bus.m_axi_awprot !== 3'b000) proto_err++;
            if (bus.m_axi_arvalid && bus.m_axi_arprot !== 3'b000) proto_err++;
            if (bus.m_axi_bready && bus.m_axi_rready) proto_err++;

            // Handshakes that completed on the previous rising edge
            if (p_awv && p_awr) begin have_aw = 1'b1; aw_addr_s = p_awaddr; aw_hs_cyc = cyc; end
            if (p_wv && p_wr) begin
                have_w = 1'b1; w_data_s = p_wdata; w_strb_s = p_wstrb; w_hs_cyc = cyc;
            end
            if (p_arv && p_arr) begin rd_pend = 1'b1; rd_addr_s = p_araddr; r_cnt = 0; end
            if (p_bv && p_br) begin bus.m_axi_bvalid = 1'b0; b_hs_count++; end
            if (p_rv && p_rr) bus.m_axi_rvalid = 1'b0;
            if (bus.mem_rvalid) rv_count++;

            // Write response
            if (have_aw && have_w && !bus.m_axi_bvalid) begin
                if (b_cnt >= b_delay) begin
                    idx = int'(aw_addr_s[5:2]);
                    for (int b = 0; b < 4; b++)
                        if (w_strb_s[b]) smem[idx][b*8 +: 8] = w_data_s[b*8 +: 8];
                    wlog.push_back('{addr: aw_addr_s, data: w_data_s, strb: w_strb_s});
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = bresp_cfg;
                    have_aw = 1'b0;
                    have_w  = 1'b0;
                    b_cnt   = 0;
                end else b_cnt++;
            end

            // Read response
            if (rd_pend && !bus.m_axi_rvalid && !r_hold) begin
                if (r_cnt >= r_delay) begin
                    idx = int'(rd_addr_s[5:2]);
                    bus.m_axi_rdata  = (idx == 0) ? {16'h0000, gpio_in} : smem[idx];
                    bus.m_axi_rresp  = rresp_cfg;
                    bus.m_axi_rvalid = 1'b1;
                    rd_pend = 1'b0;
                    r_cnt   = 0;
                end else r_cnt++;
            end

            // Ready generation after a configurable wait
            if (bus.m_axi_awvalid && !have_aw) begin
                if (aw_cnt >= aw_delay) bus.m_axi_awready = 1'b1;
                else begin bus.m_axi_awready = 1'b0; aw_cnt++; end
            end else begin bus.m_axi_awready = 1'b0; aw_cnt = 0; end
            if (bus.m_axi_wvalid && !have_w) begin
                if (w_cnt >= w_delay) bus.m_axi_wready = 1'b1;
                else begin bus.m_axi_wready = 1'b0; w_cnt++; end
            end else begin bus.m_axi_wready = 1'b0; w_cnt = 0; end
            if (bus.m_axi_arvalid && !rd_pend) begin
                if (ar_cnt >= ar_delay) bus.m_axi_arready = 1'b1;
                else begin bus.m_axi_arready = 1'b0; ar_cnt++; end
            end else begin bus.m_axi_arready = 1'b0; ar_cnt = 0; end

            p_awv = bus.m_axi_awvalid; p_awr = bus.m_axi_awready; p_awaddr = bus.m_axi_awaddr;
            p_wv  = bus.m_axi_wvalid;  p_wr  = bus.m_axi_wready;
            p_wdata = bus.m_axi_wdata; p_wstrb = bus.m_axi_wstrb;
            p_arv = bus.m_axi_arvalid; p_arr = bus.m_axi_arready; p_araddr = bus.m_axi_araddr;
            p_bv  = bus.m_axi_bvalid;  p_br  = bus.m_axi_bready;
            p_rv  = bus.m_axi_rvalid;  p_rr  = bus.m_axi_rready;
        end
    end

    // ------------------------------------------------------------ core driver
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input bit keep_req,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        int gcyc;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_be    = be;
        bus.mem_req   = 1'b1;
        #1;
        n = 0;
        while (!bus.mem_gnt && n < 200) begin @(negedge clk); #1; n++; end
        if (!bus.mem_gnt) begin
            checks++; failures++;
            $display("FAIL grant_timeout: no mem_gnt for addr %h within 200 cycles", addr);
            bus.mem_req = 1'b0; rdata = 'x; err = 1'bx; lat = -1;
            return;
        end
        gcyc = cyc;
        gnt_count++;
        last_gnt_cyc = gcyc;
        @(negedge clk);
        if (!keep_req) bus.mem_req = 1'b0;
        #1;
        n = 0;
        while (!bus.mem_rvalid && n < 200) begin @(negedge clk); #1; n++; end
        if (!bus.mem_rvalid) begin
            checks++; failures++;
            $display("FAIL rvalid_timeout: no mem_rvalid for addr %h within 200 cycles", addr);
            rdata = 'x; err = 1'bx; lat = -1;
            return;
        end
        rdata = bus.mem_rdata;
        err   = bus.mem_err;
        lat   = cyc - gcyc;
    endtask

    function automatic void shadow_write(input int idx, input logic [31:0] data, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[idx][b*8 +: 8] = data[b*8 +: 8];
    endfunction

    task automatic set_slave(input int aw, input int w, input int ar, input int bd, input int rd,
                             input logic [1:0] br, input logic [1:0] rr);
        aw_delay = aw; w_delay = w; ar_delay = ar; b_delay = bd; r_delay = rd;
        bresp_cfg = br; rresp_cfg = rr;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [39:0] outs;
        areset = 1'b1;
        bus.mem_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        outs = {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
                bus.m_axi_rready, bus.mem_rvalid, bus.mem_err, bus.mem_gnt, bus.mem_rdata};
        checks++;
        if (outs !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gpio();
        logic [31:0] rd; logic er; int lat; wr_t w;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        xfer(1'b1, 32'h04, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++;
            $display("FAIL gpio_write_resp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
        checks++; if (gpio_out !== 16'h5A5A) begin failures++;
            $display("FAIL gpio_out: got %h expected 5a5a", gpio_out); end
        checks++; if (lat !== 3) begin failures++;
            $display("FAIL write_latency: got %0d expected 3", lat); end
        w = (wlog.size() > 0) ? wlog.pop_front() : '0;
        checks++; if (w !== '{addr: 32'h04, data: 32'hA5A5_5A5A, strb: 4'hF}) begin failures++;
            $display("FAIL gpio_wlog: got %h expected %h", w, wr_t'({32'h04, 32'hA5A5_5A5A, 4'hF})); end

        xfer(1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'hA5A5_5A5A || er !== 1'b0) begin failures++;
            $display("FAIL gpio_readback: got rdata=%h err=%b expected a5a55a5a err=0", rd, er); end

        gpio_in = 16'hABCD;
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h0000_ABCD || er !== 1'b0) begin failures++;
            $display("FAIL gpio_in_read: got rdata=%h err=%b expected 0000abcd err=0", rd, er); end
        checks++; if (lat !== 3) begin failures++;
            $display("FAIL read_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_channel_order();
        logic [31:0] rd, d; logic er; int lat, b0, r0; wr_t w;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) set_slave(4, 0, 0, 0, 0, 2'b00, 2'b00);
            else           set_slave(0, 4, 0, 0, 0, 2'b00, 2'b00);
            b0 = b_hs_count; r0 = rv_count;
            d = $urandom;
            xfer(1'b1, 32'h20, d, 4'hF, 1'b0, rd, er, lat);
            shadow_write(8, d, 4'hF);
            @(negedge clk); @(negedge clk); #1;
            checks++;
            if ((pass == 0 ? aw_hs_cyc - w_hs_cyc : w_hs_cyc - aw_hs_cyc) !== 4) begin failures++;
                $display("FAIL order_gap%0d: got aw=%0d w=%0d expected 4-cycle separation",
                         pass, aw_hs_cyc, w_hs_cyc); end
            checks++; if (b_hs_count - b0 !== 1 || rv_count - r0 !== 1) begin failures++;
                $display("FAIL order_single%0d: got b=%0d rvalid=%0d expected 1 and 1",
                         pass, b_hs_count - b0, rv_count - r0); end
            checks++; if (er !== 1'b0) begin failures++;
                $display("FAIL order_err%0d: got %b expected 0", pass, er); end
            w = (wlog.size() > 0) ? wlog.pop_front() : '0;
            checks++; if (w.data !== d || w.addr !== 32'h20) begin failures++;
                $display("FAIL order_data%0d: got %h@%h expected %h@00000020", pass, w.data, w.addr, d); end
        end
    endtask

    task automatic test_error_resp();
        logic [31:0] rd, d; logic er; int lat;
        d = $urandom;
        set_slave(0, 0, 0, 0, 0, 2'b10, 2'b00);
        xfer(1'b1, 32'h24, d, 4'hF, 1'b0, rd, er, lat);
        shadow_write(9, d, 4'hF);
        void'(wlog.pop_front());
        checks++; if (er !== 1'b1) begin failures++;
            $display("FAIL slverr_write: got err=%b expected 1", er); end
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b11);
        xfer(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++;
            $display("FAIL decerr_read: got err=%b expected 1", er); end
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        xfer(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== d) begin failures++;
            $display("FAIL okay_after_err: got err=%b rdata=%h expected err=0 rdata=%h", er, rd, d); end
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b01);
        xfer(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++;
            $display("FAIL exokay_read: got err=%b expected 0", er); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp_rd; logic er, we, exp_er; logic [3:0] be; int lat, idx; wr_t w;
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(4, 15));
            d   = $urandom;
            be  = 4'($urandom_range(0, 15));
            set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (we) begin
                exp_rd = 32'h0;
                exp_er = (bresp_cfg >= 2);
                shadow_write(idx, d, be);
            end else begin
                exp_rd = shadow[idx];
                exp_er = (rresp_cfg >= 2);
            end
            xfer(we, 32'(idx * 4), d, be, 1'b0, rd, er, lat);
            checks++; if (rd !== exp_rd || er !== exp_er) begin failures++;
                $display("FAIL random%0d we=%b idx=%0d: got rdata=%h err=%b expected rdata=%h err=%b",
                         i, we, idx, rd, er, exp_rd, exp_er); end
            if (we) begin
                w = (wlog.size() > 0) ? wlog.pop_front() : '0;
                checks++; if (w !== '{addr: 32'(idx * 4), data: d, strb: be}) begin failures++;
                    $display("FAIL random_wlog%0d: got %h expected %h", i, w, wr_t'({32'(idx * 4), d, be})); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [38:0] outs; logic [31:0] rd; int n, r0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        r_hold = 1'b1;
        r0 = rv_count;
        bus.mem_we = 1'b0; bus.mem_addr = 32'h08; bus.mem_req = 1'b1;
        #1; n = 0;
        while (!bus.mem_gnt && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk); bus.mem_req = 1'b0;
        #1; n = 0;
        while (!bus.m_axi_rready && n < 50) begin @(negedge clk); #1; n++; end
        checks++; if (bus.m_axi_rready !== 1'b1) begin failures++;
            $display("FAIL reach_rd_resp: got rready=%b expected 1", bus.m_axi_rready); end
        areset = 1'b1;
        @(negedge clk); #1;
        outs = {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
                bus.m_axi_rready, bus.mem_rvalid, bus.mem_err, bus.mem_rdata};
        checks++; if (outs !== 39'h0) begin failures++;
            $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
        areset = 1'b0;
        r_hold = 1'b0;
        gpio_in = 16'h1357;
        bus.mem_we = 1'b0; bus.mem_addr = 32'h00; bus.mem_req = 1'b1;
        #1;
        checks++; if (bus.mem_gnt !== 1'b1) begin failures++;
            $display("FAIL post_reset_grant: got %b expected 1", bus.mem_gnt); end
        @(negedge clk); bus.mem_req = 1'b0;
        #1; n = 0;
        while (!bus.mem_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        rd = bus.mem_rdata;
        checks++; if (bus.mem_rvalid !== 1'b1 || rd !== 32'h0000_1357) begin failures++;
            $display("FAIL post_reset_read: got rvalid=%b rdata=%h expected 1 00001357", bus.mem_rvalid, rd); end
        @(negedge clk); @(negedge clk); #1;
        checks++; if (rv_count - r0 !== 1) begin failures++;
            $display("FAIL abandoned_pulse: got %0d mem_rvalid pulses expected 1", rv_count - r0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, data [10]; logic er; int lat, g0, r0, first_gnt; wr_t w;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        wlog.delete();
        @(negedge clk);
        g0 = gnt_count; r0 = rv_count; first_gnt = 0;
        for (int i = 0; i < 10; i++) begin
            data[i] = $urandom;
            xfer(1'b1, 32'h10 + 32'(i * 4), data[i], 4'hF, (i < 9), rd, er, lat);
            if (i == 0) first_gnt = last_gnt_cyc;
            shadow_write(4 + i, data[i], 4'hF);
        end
        @(negedge clk); @(negedge clk); #1;
        checks++; if (gnt_count - g0 !== 10 || rv_count - r0 !== 10) begin failures++;
            $display("FAIL b2b_counts: got grants=%0d rvalid=%0d expected 10 and 10",
                     gnt_count - g0, rv_count - r0); end
        checks++; if (last_gnt_cyc - first_gnt !== 27) begin failures++;
            $display("FAIL b2b_throughput: got %0d cycles first-to-last grant expected 27",
                     last_gnt_cyc - first_gnt); end
        for (int i = 0; i < 10; i++) begin
            w = (wlog.size() > 0) ? wlog.pop_front() : '0;
            checks++; if (w.data !== data[i] || w.addr !== 32'h10 + 32'(i * 4)) begin failures++;
                $display("FAIL b2b_order%0d: got %h@%h expected %h@%h",
                         i, w.data, w.addr, data[i], 32'h10 + 32'(i * 4)); end
        end
    endtask

    task automatic test_protocol();
        checks++; if (proto_err !== 0) begin failures++;
            $display("FAIL axi_protocol: got %0d violations expected 0", proto_err); end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        areset = 1'b1;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_be = '0;
        bus.mem_addr = '0;  bus.mem_wdata = '0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        r_hold = 1'b0; gpio_in = 16'h0;
        {aw_hs_cyc, w_hs_cyc, b_hs_count, rv_count, proto_err, gnt_count, last_gnt_cyc} = '0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;

        test_reset();
        test_gpio();
        test_channel_order();
        test_error_resp();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_protocol();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
